// File: rtl/d16_xalu_pkg.sv
// Shared op codes, FSM state encoding and the iterative-op classifier for d16_xalu.
package d16_xalu_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SHL = 4'd3;
  localparam logic [3:0] OP_SHR = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;
  localparam logic [3:0] OP_LE  = 4'd8;
  localparam logic [3:0] OP_GE  = 4'd9;
  localparam logic [3:0] OP_LT  = 4'd10;
  localparam logic [3:0] OP_GT  = 4'd11;
  localparam logic [3:0] OP_XOR = 4'd12;
  localparam logic [3:0] OP_MUL = 4'd13;
  localparam logic [3:0] OP_DIV = 4'd14;
  localparam logic [3:0] OP_MOD = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  // Only the zero-ness of b matters, so callers may pass any zero-extended view of it.
  function automatic logic is_iter(input logic [3:0] op, input logic [63:0] b);
    return (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && (b != 64'd0));
  endfunction

endpackage

// File: rtl/d16_xalu_iter.sv
// Shift-add multiplier / restoring divider, one step per cycle, WIDTH steps per op.
// done is high during the final step; *_nxt carry that step's result combinationally.
module d16_xalu_iter
  import d16_xalu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       start_op,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] sh_nxt
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic             mul_q;
  logic [WIDTH-1:0] acc_q;  // product high half, or partial remainder
  logic [WIDTH-1:0] sh_q;   // multiplier shifting out, or dividend in / quotient out
  logic [WIDTH-1:0] opd_q;  // multiplicand or divisor
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;
  logic           ge;

  always_comb begin
    sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opd_q} : '0);
    trial = {acc_q, sh_q[WIDTH-1]};
    ge    = trial >= {1'b0, opd_q};
    if (mul_q) begin
      acc_nxt = sum[WIDTH:1];
      sh_nxt  = {sum[0], sh_q[WIDTH-1:1]};
    end else begin
      acc_nxt = ge ? WIDTH'(trial - {1'b0, opd_q}) : trial[WIDTH-1:0];
      sh_nxt  = {sh_q[WIDTH-2:0], ge};
    end
  end

  assign done = step && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_q <= 1'b0;
      acc_q <= '0;
      sh_q  <= '0;
      opd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      mul_q <= (start_op == OP_MUL);
      acc_q <= '0;
      sh_q  <= (start_op == OP_MUL) ? b : a;
      opd_q <= (start_op == OP_MUL) ? a : b;
      cnt_q <= '0;
    end else if (step) begin
      acc_q <= acc_nxt;
      sh_q  <= sh_nxt;
      if (cnt_q != FULL) cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/d16_xalu.sv
// Multi-cycle d16 ALU: single-cycle ops complete one edge after accept, MUL/DIV/MOD take WIDTH+1.
// in_ready drops while an iterative op runs; there is no output back-pressure.
module d16_xalu
  import d16_xalu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             o
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH:0] WLIM = (WIDTH + 1)'(WIDTH);

  state_t     state;
  logic [3:0] op_q;
  logic       accept;
  logic       go_iter;
  logic       step_done;

  logic [WIDTH-1:0] it_acc;
  logic [WIDTH-1:0] it_sh;
  logic [WIDTH-1:0] it_s;
  logic             it_o;

  logic [WIDTH-1:0] sc_s;
  logic             sc_c;
  logic             sc_o;
  logic [WIDTH:0]   add_r;
  logic [WIDTH:0]   sub_r;
  logic [WIDTH:0]   shl_r;
  logic [WIDTH:0]   shr_r;
  logic [SW-1:0]    sh;
  logic             sh_big;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign go_iter  = accept && is_iter(op, 64'(|b));

  d16_xalu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .start    (go_iter),
    .start_op (op),
    .step     (state == ITER),
    .a        (a),
    .b        (b),
    .done     (step_done),
    .acc_nxt  (it_acc),
    .sh_nxt   (it_sh)
  );

  // The extra bit on each shift catches the last bit shifted out; it stays 0 for a zero shift.
  always_comb begin
    sh     = b[SW-1:0];
    sh_big = {1'b0, b} >= WLIM;
    add_r  = {1'b0, a} + {1'b0, b};
    sub_r  = {1'b0, a} - {1'b0, b};
    shl_r  = {1'b0, a} << sh;
    shr_r  = {a, 1'b0} >> sh;
    sc_s   = '0;
    sc_c   = 1'b0;
    sc_o   = 1'b0;
    case (op)
      OP_ADD: begin
        sc_s = add_r[WIDTH-1:0];
        sc_c = add_r[WIDTH];
        sc_o = (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_s = sub_r[WIDTH-1:0];
        sc_c = sub_r[WIDTH];
        sc_o = (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHL: begin
        if (!sh_big) begin
          sc_s = shl_r[WIDTH-1:0];
          sc_c = shl_r[WIDTH];
        end
      end
      OP_SHR: begin
        if (!sh_big) begin
          sc_s = shr_r[WIDTH:1];
          sc_c = shr_r[0];
        end
      end
      OP_OR:  sc_s = a | b;
      OP_AND: sc_s = a & b;
      OP_XOR: sc_s = a ^ b;
      OP_EQ:  sc_s = WIDTH'(a == b);
      OP_LE:  sc_s = WIDTH'(a <= b);
      OP_GE:  sc_s = WIDTH'(a >= b);
      OP_LT:  sc_s = WIDTH'(a < b);
      OP_GT:  sc_s = WIDTH'(a > b);
      // DIV/MOD only reach this path with b == 0.
      OP_DIV: begin
        sc_s = '1;
        sc_o = 1'b1;
      end
      OP_MOD: begin
        sc_s = a;
        sc_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    it_s = it_sh;
    it_o = 1'b0;
    if (op_q == OP_MUL) it_o = |it_acc;
    else if (op_q == OP_MOD) it_s = it_acc;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      op_q      <= OP_NOP;
      out_valid <= 1'b0;
      s         <= '0;
      n         <= 1'b0;
      z         <= 1'b0;
      c         <= 1'b0;
      o         <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (go_iter) begin
              state <= ITER;
              op_q  <= op;
            end else begin
              out_valid <= 1'b1;
              if (op != OP_NOP) begin
                s <= sc_s;
                n <= sc_s[WIDTH-1];
                z <= ~|sc_s;
                c <= sc_c;
                o <= sc_o;
              end
            end
          end
        end
        ITER: begin
          if (step_done) begin
            state     <= IDLE;
            out_valid <= 1'b1;
            s         <= it_s;
            n         <= it_s[WIDTH-1];
            z         <= ~|it_s;
            c         <= 1'b0;
            o         <= it_o;
          end
        end
      endcase
    end
  end

endmodule
